// File: rtl/adam_jtag_dtm.sv
// JTAG debug transport module: IEEE 1149.1 TAP with IDCODE, DTMCS and DMI data registers,
// bridging DMI scans onto a valid/ready request/response interface to a debug module.
module adam_jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  parameter int unsigned ABITS  = 7,
  parameter int unsigned IDLE   = 1
) (
  input  logic             tck_i,
  input  logic             trst_ni,
  input  logic             tms_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic             tdo_en_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_rsp_valid_i,
  output logic             dmi_rsp_ready_o,
  input  logic [31:0]      dmi_rsp_data_i,
  input  logic [1:0]       dmi_rsp_resp_i,
  output logic             dmi_hardreset_o
);

  localparam int unsigned DmiW = ABITS + 34;

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  typedef enum logic [3:0] {
    StTestLogicReset,
    StRunTestIdle,
    StSelectDr,
    StCaptureDr,
    StShiftDr,
    StExit1Dr,
    StPauseDr,
    StExit2Dr,
    StUpdateDr,
    StSelectIr,
    StCaptureIr,
    StShiftIr,
    StExit1Ir,
    StPauseIr,
    StExit2Ir,
    StUpdateIr
  } tap_state_e;

  typedef enum logic [1:0] {TxIdle, TxReq, TxRsp} tx_state_e;

  tap_state_e tap_q, tap_d;
  tx_state_e  tx_q, tx_d, tx_eff;

  logic [4:0]      ir_q, ir_d;
  logic [4:0]      ir_sh_q, ir_sh_d;
  logic [DmiW-1:0] dr_q, dr_d;
  logic [6:0]      dr_msb;

  logic [ABITS-1:0] last_addr_q, last_addr_d;
  logic [31:0]      last_data_q, last_data_d, data_eff;
  logic [1:0]       dmistat_q, dmistat_d, stat_eff;
  logic [1:0]       req_op_q, req_op_d;
  logic             hardreset_q, hardreset_d;
  logic             rsp_fire, busy;

  logic tdo_q, tdo_d;
  logic tdo_en_q, tdo_en_d;

  // TAP controller
  always_comb begin
    tap_d = tap_q;
    unique case (tap_q)
      StTestLogicReset: tap_d = tms_i ? StTestLogicReset : StRunTestIdle;
      StRunTestIdle:    tap_d = tms_i ? StSelectDr       : StRunTestIdle;
      StSelectDr:       tap_d = tms_i ? StSelectIr       : StCaptureDr;
      StCaptureDr:      tap_d = tms_i ? StExit1Dr        : StShiftDr;
      StShiftDr:        tap_d = tms_i ? StExit1Dr        : StShiftDr;
      StExit1Dr:        tap_d = tms_i ? StUpdateDr       : StPauseDr;
      StPauseDr:        tap_d = tms_i ? StExit2Dr        : StPauseDr;
      StExit2Dr:        tap_d = tms_i ? StUpdateDr       : StShiftDr;
      StUpdateDr:       tap_d = tms_i ? StSelectDr       : StRunTestIdle;
      StSelectIr:       tap_d = tms_i ? StTestLogicReset : StCaptureIr;
      StCaptureIr:      tap_d = tms_i ? StExit1Ir        : StShiftIr;
      StShiftIr:        tap_d = tms_i ? StExit1Ir        : StShiftIr;
      StExit1Ir:        tap_d = tms_i ? StUpdateIr       : StPauseIr;
      StPauseIr:        tap_d = tms_i ? StExit2Ir        : StPauseIr;
      StExit2Ir:        tap_d = tms_i ? StUpdateIr       : StShiftIr;
      StUpdateIr:       tap_d = tms_i ? StSelectDr       : StRunTestIdle;
      default:          tap_d = StTestLogicReset;
    endcase
  end

  // Instruction register
  always_comb begin
    ir_d    = ir_q;
    ir_sh_d = ir_sh_q;
    if (tap_q == StTestLogicReset) ir_d = IrIdcode;
    if (tap_q == StCaptureIr) ir_sh_d = 5'b00001;
    if (tap_q == StShiftIr) ir_sh_d = {tdi_i, ir_sh_q[4:1]};
    if (tap_q == StUpdateIr) ir_d = ir_sh_q;
  end

  // DMI transaction tracking; a response in this cycle is folded in before capture/update.
  always_comb begin
    rsp_fire = (tx_q == TxRsp) && dmi_rsp_valid_i;
    data_eff = last_data_q;
    stat_eff = dmistat_q;
    tx_eff   = tx_q;
    if (rsp_fire) begin
      tx_eff = TxIdle;
      // writes keep the written data as last_data
      if (req_op_q == OpRead) data_eff = dmi_rsp_data_i;
      if (dmistat_q == 2'd0 && dmi_rsp_resp_i[1]) stat_eff = dmi_rsp_resp_i;
    end
    busy = (tx_eff != TxIdle);

    tx_d        = tx_eff;
    last_addr_d = last_addr_q;
    last_data_d = data_eff;
    dmistat_d   = stat_eff;
    req_op_d    = req_op_q;
    hardreset_d = 1'b0;

    if (tx_q == TxReq && dmi_req_ready_i) tx_d = TxRsp;

    if (ir_q == IrDmi) begin
      if (tap_q == StCaptureDr && busy) dmistat_d = 2'd3;
      if (tap_q == StUpdateDr) begin
        if (busy) begin
          dmistat_d = 2'd3;
        end else if (stat_eff == 2'd0 && (dr_q[1:0] == OpRead || dr_q[1:0] == OpWrite)) begin
          last_addr_d = dr_q[DmiW-1:34];
          last_data_d = dr_q[33:2];
          req_op_d    = dr_q[1:0];
          tx_d        = TxReq;
        end
      end
    end

    if (ir_q == IrDtmcs && tap_q == StUpdateDr) begin
      if (dr_q[16] || dr_q[17]) dmistat_d = 2'd0;
      if (dr_q[17]) begin
        tx_d        = TxIdle;
        hardreset_d = 1'b1;
      end
    end
  end

  // Data register: one shared shifter, tdi enters at the MSB of the selected length
  always_comb begin
    unique case (ir_q)
      IrIdcode: dr_msb = 7'd31;
      IrDtmcs:  dr_msb = 7'd31;
      IrDmi:    dr_msb = 7'(DmiW - 1);
      default:  dr_msb = 7'd0;
    endcase
  end

  always_comb begin
    dr_d = dr_q;
    if (tap_q == StCaptureDr) begin
      dr_d = '0;
      unique case (ir_q)
        IrIdcode: dr_d[31:0] = IDCODE;
        IrDtmcs:  dr_d[31:0] = {14'b0, 2'b0, 1'b0, 3'(IDLE), stat_eff, 6'(ABITS), 4'd1};
        IrDmi:    dr_d = {last_addr_q, data_eff, busy ? 2'd3 : stat_eff};
        default:  dr_d = '0;
      endcase
    end else if (tap_q == StShiftDr) begin
      dr_d = (dr_q >> 1) | (DmiW'(tdi_i) << dr_msb);
    end
  end

  always_comb begin
    tdo_en_d = (tap_q == StShiftDr) || (tap_q == StShiftIr);
    tdo_d    = (tap_q == StShiftIr) ? ir_sh_q[0] : dr_q[0];
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tap_q       <= StTestLogicReset;
      ir_q        <= IrIdcode;
      ir_sh_q     <= '0;
      dr_q        <= '0;
      tx_q        <= TxIdle;
      last_addr_q <= '0;
      last_data_q <= '0;
      dmistat_q   <= '0;
      req_op_q    <= '0;
      hardreset_q <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      ir_q        <= ir_d;
      ir_sh_q     <= ir_sh_d;
      dr_q        <= dr_d;
      tx_q        <= tx_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      dmistat_q   <= dmistat_d;
      req_op_q    <= req_op_d;
      hardreset_q <= hardreset_d;
    end
  end

  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo_o           = tdo_q;
  assign tdo_en_o        = tdo_en_q;
  assign dmi_req_valid_o = (tx_q == TxReq);
  assign dmi_rsp_ready_o = (tx_q == TxRsp);
  assign dmi_req_addr_o  = last_addr_q;
  assign dmi_req_data_o  = last_data_q;
  assign dmi_req_op_o    = req_op_q;
  assign dmi_hardreset_o = hardreset_q;

endmodule

// File: tb/tb_adam_jtag_dtm.sv
// Scoreboard bench for adam_jtag_dtm: scans and DMI requests are checked against queued
// expectations by independent monitor processes.
module tb_adam_jtag_dtm;

  localparam logic [31:0] IdCode = 32'h1BAD_C0DF;

  logic        tck, trst_n, tms, tdi, tdo, tdo_en;
  logic        dmi_req_valid, dmi_req_ready, dmi_rsp_valid, dmi_rsp_ready, dmi_hardreset;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_rsp_data;
  logic [1:0]  dmi_req_op, dmi_rsp_resp;

  adam_jtag_dtm #(.IDCODE(IdCode), .ABITS(7), .IDLE(1)) dut (
    .tck_i           (tck),
    .trst_ni         (trst_n),
    .tms_i           (tms),
    .tdi_i           (tdi),
    .tdo_o           (tdo),
    .tdo_en_o        (tdo_en),
    .dmi_req_valid_o (dmi_req_valid),
    .dmi_req_ready_i (dmi_req_ready),
    .dmi_req_addr_o  (dmi_req_addr),
    .dmi_req_data_o  (dmi_req_data),
    .dmi_req_op_o    (dmi_req_op),
    .dmi_rsp_valid_i (dmi_rsp_valid),
    .dmi_rsp_ready_o (dmi_rsp_ready),
    .dmi_rsp_data_i  (dmi_rsp_data),
    .dmi_rsp_resp_i  (dmi_rsp_resp),
    .dmi_hardreset_o (dmi_hardreset)
  );

  typedef struct {logic [63:0] val; string nm;} scan_exp_t;
  typedef struct {logic [63:0] val; logic [1:0] en;} scan_obs_t;
  typedef struct {logic [6:0] a; logic [31:0] d; logic [1:0] op;} req_t;

  scan_exp_t exp_scan[$];
  scan_obs_t obs_q[$];
  req_t      exp_req[$];

  int n_assert = 0;
  int n_fail   = 0;
  int hr_cnt   = 0;

  logic        ready_en = 1'b1;
  logic [31:0] rsp_data_cfg = '0;
  logic [1:0]  rsp_resp_cfg = '0;
  logic        rsp_pend = 1'b0;
  logic        rsp_fire_pend = 1'b0;

  initial tck = 1'b0;
  always #10 tck = ~tck;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] s);
    return {23'b0, a, d, s};
  endfunction

  // Scan monitor: pops expectation for every completed checked scan
  scan_obs_t mon_o;
  scan_exp_t mon_e;
  initial forever begin
    wait (obs_q.size() != 0);
    mon_o = obs_q.pop_front();
    if (exp_scan.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scan_unexpected: got %h expected none", mon_o.val);
    end else begin
      mon_e = exp_scan.pop_front();
      check(mon_e.nm, mon_o.val, mon_e.val);
      check({mon_e.nm, "_tdo_en"}, 64'(mon_o.en), 64'd2);
    end
  end

  // DM model and request monitor
  req_t rq;
  initial begin
    dmi_req_ready = 1'b0;
    dmi_rsp_valid = 1'b0;
    dmi_rsp_data  = '0;
    dmi_rsp_resp  = '0;
    forever begin
      @(negedge tck);
      #2;
      if (rsp_fire_pend) begin
        dmi_rsp_valid = 1'b0;
        rsp_fire_pend = 1'b0;
      end
      dmi_req_ready = ready_en;
      if (rsp_pend && !dmi_rsp_valid) begin
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = rsp_data_cfg;
        dmi_rsp_resp  = rsp_resp_cfg;
        rsp_pend      = 1'b0;
      end
      #3;
      if (dmi_hardreset) hr_cnt++;
      if (dmi_req_valid && dmi_req_ready) begin
        if (exp_req.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h data %h op %0d expected none",
                   dmi_req_addr, dmi_req_data, dmi_req_op);
        end else begin
          rq = exp_req.pop_front();
          check("req_addr", 64'(dmi_req_addr), 64'(rq.a));
          check("req_data", 64'(dmi_req_data), 64'(rq.d));
          check("req_op", 64'(dmi_req_op), 64'(rq.op));
        end
        rsp_pend = 1'b1;
      end
      if (dmi_rsp_valid && dmi_rsp_ready) rsp_fire_pend = 1'b1;
    end
  end

  task automatic step(input logic m, input logic d, output logic o, output logic en);
    @(negedge tck);
    #1;
    o   = tdo;
    en  = tdo_en;
    tms = m;
    tdi = d;
    @(posedge tck);
  endtask

  task automatic idle(input int n);
    logic o, en;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, o, en);
  endtask

  // Full scan from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input bit is_ir, input int len, input logic [63:0] din, input bit chk,
                      input logic [63:0] exp, input string nm);
    logic [63:0] dout;
    logic        o, en, en_all, en_upd;
    scan_obs_t   ob;
    dout   = '0;
    en_all = 1'b1;
    if (chk) exp_scan.push_back('{val: exp, nm: nm});
    step(1'b1, 1'b0, o, en);
    if (is_ir) step(1'b1, 1'b0, o, en);
    step(1'b0, 1'b0, o, en);
    step(1'b0, 1'b0, o, en);
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, din[i], o, en);
      dout[i] = o;
      en_all  = en_all & en;
    end
    step(1'b1, 1'b0, o, en);
    step(1'b0, 1'b0, o, en_upd);
    if (chk) begin
      ob.val = dout;
      ob.en  = {en_all, en_upd};
      obs_q.push_back(ob);
    end
  endtask

  task automatic ir_scan(input logic [4:0] ir);
    scan(1'b1, 5, 64'(ir), 1'b1, 64'd1, "ir_capture");
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input logic [63:0] exp, input string nm);
    scan(1'b0, 41, dmi_word(a, d, op), 1'b1, exp, nm);
  endtask

  initial begin
    tms    = 1'b1;
    tdi    = 1'b0;
    trst_n = 1'b0;
    #35;
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
    check("rst_rsp_ready", 64'(dmi_rsp_ready), 64'd0);
    check("rst_hardreset", 64'(dmi_hardreset), 64'd0);
    check("rst_payload", {dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
    @(negedge tck);
    trst_n = 1'b1;
    idle(2);

    // IDCODE is the reset instruction; then explicit selection and DTMCS
    scan(1'b0, 32, 64'd0, 1'b1, 64'(IdCode), "idcode_reset_ir");
    ir_scan(5'h01);
    scan(1'b0, 32, 64'd0, 1'b1, 64'(IdCode), "idcode");
    ir_scan(5'h10);
    scan(1'b0, 32, 64'd0, 1'b1, 64'h1071, "dtmcs");
    ir_scan(5'h1F);
    scan(1'b0, 1, 64'd1, 1'b1, 64'd0, "bypass");

    // DMI write, then read with response data
    ir_scan(5'h11);
    rsp_data_cfg = 32'h1234_5678;
    exp_req.push_back('{a: 7'h10, d: 32'hFFFF_FFFF, op: 2'd2});
    dmi_scan(7'h10, 32'hFFFF_FFFF, 2'd2, dmi_word(0, 0, 0), "dmi_cap_reset");
    idle(8);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h10, 32'hFFFF_FFFF, 0), "dmi_after_write");
    rsp_data_cfg = 32'h0000_0382;
    exp_req.push_back('{a: 7'h11, d: 32'h0, op: 2'd1});
    dmi_scan(7'h11, 32'h0, 2'd1, dmi_word(7'h10, 32'hFFFF_FFFF, 0), "dmi_before_read");
    idle(8);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h11, 32'h382, 0), "dmi_read_data");

    // Busy: stall the request, issue another op
    ready_en     = 1'b0;
    rsp_data_cfg = 32'hDEAD_DEAD;
    exp_req.push_back('{a: 7'h05, d: 32'hA5A5_A5A5, op: 2'd2});
    dmi_scan(7'h05, 32'hA5A5_A5A5, 2'd2, dmi_word(7'h11, 32'h382, 0), "dmi_before_busy");
    idle(3);
    dmi_scan(7'h06, 32'h0, 2'd1, dmi_word(7'h05, 32'hA5A5_A5A5, 3), "dmi_busy_cap");
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h05, 32'hA5A5_A5A5, 3), "dmi_busy_sticky");
    ready_en = 1'b1;
    idle(8);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h05, 32'hA5A5_A5A5, 3), "dmi_write_preserve");
    ir_scan(5'h10);
    scan(1'b0, 32, 64'h1_0000, 1'b1, 64'h1C71, "dtmcs_busy");
    scan(1'b0, 32, 64'd0, 1'b1, 64'h1071, "dtmcs_dmireset");

    // Failed response, then hard reset
    ir_scan(5'h11);
    rsp_data_cfg = 32'hCAFE_F00D;
    rsp_resp_cfg = 2'd2;
    exp_req.push_back('{a: 7'h07, d: 32'h0, op: 2'd1});
    dmi_scan(7'h07, 32'h0, 2'd1, dmi_word(7'h05, 32'hA5A5_A5A5, 0), "dmi_accept_again");
    idle(8);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h07, 32'hCAFE_F00D, 2), "dmi_failed");
    ir_scan(5'h10);
    hr_cnt = 0;
    scan(1'b0, 32, 64'h2_0000, 1'b1, 64'h1871, "dtmcs_failed");
    idle(4);
    check("hardreset_pulse", 64'(hr_cnt), 64'd1);
    scan(1'b0, 32, 64'd0, 1'b1, 64'h1071, "dtmcs_hardreset");

    // TLR via tms keeps the outstanding request; trst abandons it
    ir_scan(5'h11);
    ready_en     = 1'b0;
    rsp_resp_cfg = 2'd0;
    exp_req.push_back('{a: 7'h09, d: 32'h0, op: 2'd1});
    dmi_scan(7'h09, 32'h0, 2'd1, dmi_word(7'h07, 32'hCAFE_F00D, 0), "dmi_before_tlr");
    idle(3);
    for (int i = 0; i < 5; i++) begin
      logic o, en;
      step(1'b1, 1'b0, o, en);
    end
    idle(1);
    ir_scan(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h09, 32'h0, 3), "dmi_after_tlr");
    @(negedge tck);
    #4;
    check("tlr_req_valid", 64'(dmi_req_valid), 64'd1);
    trst_n = 1'b0;
    #1;
    check("trst_req_valid", 64'(dmi_req_valid), 64'd0);
    check("trst_rsp_ready", 64'(dmi_rsp_ready), 64'd0);
    check("trst_req_addr", 64'(dmi_req_addr), 64'd0);
    exp_req.delete();
    ready_en = 1'b1;
    idle(3);
    @(negedge tck);
    #3;
    trst_n = 1'b1;
    idle(2);
    ir_scan(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(0, 0, 0), "dmi_after_trst");
    idle(10);
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("scan_queue_empty", 64'(exp_scan.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_jtag_dtm.md
ADAM_JTAG_DTM -- requirements
Module: adam_jtag_dtm

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, value shifted out by the IDCODE instruction.
REQ-002 SHALL have parameter ABITS, default 7, DMI address width, range 7..32.
REQ-003 SHALL have parameter IDLE, default 1, Run-Test/Idle cycles advertised in DTMCS, range 0..7.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: tck in 1 (JTAG clock, sole clock), trst_n in 1 (async active-low reset).
REQ-005 tms in 1, tdi in 1: TAP mode select and serial data in, sampled on rising tck.
REQ-006 tdo out 1, tdo_en out 1: serial data out and output enable, both updated on falling tck.
REQ-007 dmi_req_valid out 1, dmi_req_ready in 1: DMI request handshake.
REQ-008 dmi_req_addr out ABITS, dmi_req_data out 32, dmi_req_op out 2: request payload; op 1 = read, 2 = write.
REQ-009 dmi_rsp_valid in 1, dmi_rsp_ready out 1: DMI response handshake.
REQ-010 dmi_rsp_data in 32, dmi_rsp_resp in 2: response payload; 0 = ok, 2 = failed, 3 = busy.
REQ-011 dmi_hardreset out 1: one-tck pulse requesting a DM-side DMI reset.

Function
REQ-012 SHALL implement the 16-state IEEE 1149.1 TAP FSM on rising tck; 5 consecutive tms=1 SHALL reach Test-Logic-Reset from any state.
REQ-013 IR SHALL be 5 bits; Capture-IR SHALL load 5'b00001; IR SHALL update on Update-IR; Test-Logic-Reset SHALL set IR to 0x01.
REQ-014 Decode: 0x01 IDCODE (32 b), 0x10 DTMCS (32 b), 0x11 DMI (ABITS+34 b); every other code SHALL select 1-bit BYPASS, which captures 0.
REQ-015 Shift-DR/IR SHALL shift LSB first, tdi entering at the MSB; tdo = LSB of the selected register; tdo_en=1 only in Shift-DR/Shift-IR.
REQ-016 DTMCS read value SHALL be {14'b0, 2'b0, 1'b0, IDLE[2:0], dmistat[1:0], ABITS[5:0], 4'd1}.
REQ-017 DTMCS Update-DR: bit 16 (dmireset) SHALL clear dmistat; bit 17 (dmihardreset) SHALL clear dmistat, drop any pending request/response and pulse dmi_hardreset for 1 cycle.
REQ-018 DMI Capture-DR SHALL load {last_addr, last_data, dmistat}; if a request is outstanding at capture, dmistat SHALL become 3 (sticky) and 3 SHALL be captured.
REQ-019 DMI Update-DR with op 1 or 2, dmistat==0 and nothing outstanding SHALL latch addr/data/op and assert dmi_req_valid on the next cycle; op 0 or 3 SHALL issue nothing.
REQ-020 DMI Update-DR while a request is outstanding, or while dmistat!=0, SHALL issue nothing; an outstanding request SHALL also set dmistat=3.
REQ-021 dmi_req_valid and the payload SHALL hold stable until dmi_req_ready; at most one transaction SHALL be outstanding.
REQ-022 dmi_rsp_ready SHALL be 1 while awaiting a response; on the handshake, last_data SHALL take dmi_rsp_data; resp 2 or 3 SHALL set dmistat to resp if dmistat==0.
REQ-023 A write response SHALL preserve the data written as last_data.
REQ-024 A response arriving in the same cycle as a DMI Capture-DR SHALL complete first; capture then sees the updated data and status.
REQ-025 dmistat codes SHALL be sticky and cleared only by dmireset, dmihardreset or reset.

Reset
REQ-026 trst_n low SHALL asynchronously force: TAP = Test-Logic-Reset, IR = 0x01, dmistat = 0, last_addr = 0, last_data = 0, nothing outstanding.
REQ-027 Reset values of outputs SHALL be: tdo=0, tdo_en=0, dmi_req_valid=0, dmi_rsp_ready=0, dmi_hardreset=0, request payload = 0.
REQ-028 Reset during an outstanding transaction SHALL abandon it; a later dmi_rsp_valid SHALL be ignored.
REQ-029 Entering Test-Logic-Reset via tms SHALL reset only the TAP FSM and IR; dmistat and an outstanding transaction SHALL be unaffected.

Verification
REQ-030 trst_n pulse, then IR=0x01 and shift 32 -> IDCODE; IR=0x10 and shift 32 -> 32'h0000_1071 (IDLE=1, ABITS=7).
REQ-031 DMI write addr 0x10 data 0xFFFF_FFFF op 2, ready=1, resp 0 -> one request with addr 0x10, data 0xFFFFFFFF, op 2; next capture op field = 0.
REQ-032 DMI read addr 0x11 with dmi_rsp_data 0x0000_0382 -> next DMI capture returns data 0x382 and op field 0.
REQ-033 Hold dmi_req_ready=0 and issue a second DMI op -> captured op = 3 and no second request; DTMCS write with bit 16 set -> dmistat=0 and DMI accepted again.
REQ-034 dmi_rsp_resp=2 -> DTMCS dmistat=2; DTMCS write with bit 17 set -> dmi_hardreset high for exactly 1 cycle and dmistat=0.
REQ-035 Assert trst_n low while dmi_req_valid=1 -> dmi_req_valid=0 immediately and TAP in Test-Logic-Reset; IR capture after release -> 5'b00001.
